// File: rtl/guess_round_ctrl.sv
// Round controller for the guessing game. It seeds the target, sequences guesses
// against a try limit, declares win/lose, blinks on a win and keeps a score.
module guess_round_ctrl #(
  parameter int MAX_TRIES    = 8,
  parameter int TRY_W        = 4,
  parameter int BLINK_CYCLES = 25000000,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enter,
  input  logic               i_over,
  input  logic               i_under,
  input  logic               i_equal,
  output logic               o_inc_actual,
  output logic               o_update_leds,
  output logic [TRY_W-1:0]   o_tries,
  output logic               o_win,
  output logic               o_lose,
  output logic               o_blink,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_fault
);

  localparam int BLINK_W = $clog2(BLINK_CYCLES);

  typedef enum logic [2:0] {
    S_SEED    = 3'd0,
    S_COMPARE = 3'd1,
    S_GUESS   = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  state_t             state;
  logic               enter_q;
  logic [BLINK_W-1:0] blink_cnt;
  logic               enter_ev;

  // Acting on the release edge makes one press advance exactly one step.
  assign enter_ev = enter_q & ~i_enter;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // sees the pre-edge values and later assignments simply override earlier ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SEED;
      enter_q   <= 1'b0;
      o_tries   <= '0;
      o_score   <= '0;
      o_blink   <= 1'b0;
      o_fault   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      enter_q   <= i_enter;
      o_blink   <= 1'b0;
      blink_cnt <= '0;
      case (state)
        S_SEED: begin
          o_tries <= '0;
          if (enter_ev) state <= S_COMPARE;
        end
        S_COMPARE: begin
          o_tries <= o_tries + TRY_W'(1);
          if (!$onehot({i_over, i_under, i_equal})) o_fault <= 1'b1;
          if (i_equal) begin
            state   <= S_WIN;
            o_score <= o_score + SCORE_W'(1);
            o_blink <= 1'b1;
          end else if (o_tries == TRY_W'(MAX_TRIES - 1)) begin
            state <= S_LOSE;
          end else begin
            state <= S_GUESS;
          end
        end
        S_GUESS: begin
          if (enter_ev) state <= S_COMPARE;
        end
        S_WIN: begin
          if (enter_ev) begin
            state   <= S_SEED;
            o_tries <= '0;
          end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            o_blink <= ~o_blink;
          end else begin
            o_blink   <= o_blink;
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
        S_LOSE: begin
          if (enter_ev) begin
            state   <= S_SEED;
            o_tries <= '0;
          end
        end
        default: state <= S_SEED;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    o_inc_actual  = 1'b0;
    o_update_leds = 1'b0;
    o_win         = 1'b0;
    o_lose        = 1'b0;
    case (state)
      S_SEED:    o_inc_actual  = 1'b1;
      S_COMPARE: o_update_leds = 1'b1;
      S_WIN:     o_win         = 1'b1;
      S_LOSE:    o_lose        = 1'b1;
      default:   ;
    endcase
  end

endmodule
